// File: rtl/pixgen_pkg.sv
// Shared types and constants for the pixel generator output path.
// Contents:
//   rgb_t           - 24-bit pixel {r, g, b}; b occupies the least significant byte
//   phase_e         - position of a pixel inside a 4-pixel / 3-word packing group
//   words_per_line  - number of 32-bit words produced by one line of pixels
package pixgen_pkg;

    localparam int PIX_BITS        = 24;
    localparam int WORD_BITS       = 32;
    localparam int PIX_PER_GROUP   = 4;
    localparam int WORDS_PER_GROUP = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    function automatic int words_per_line(input int x_pixels);
        return (x_pixels * WORDS_PER_GROUP) / PIX_PER_GROUP;
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// AXI-Stream bundle carrying the packed 32-bit words towards VDMA.
// Signals: tdata (32), tkeep (4), tlast, tuser, tvalid from the producer;
//          tready from the consumer.
// Modports: master = stream producer, slave = stream consumer.
interface pixel_packer_if;
    import pixgen_pkg::*;

    logic [WORD_BITS-1:0] tdata;
    logic [3:0]           tkeep;
    logic                 tlast;
    logic                 tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tkeep, output tlast, output tuser,
                    output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tuser,
                    input tvalid, output tready);
endinterface

// File: rtl/axis_frame_counter.sv
// Word/line position tracker for a video AXI-Stream producer.
// Ports:
//   clk_i, rst_i - clock and synchronous active-high reset
//   advance_i    - a word is being issued this cycle; step the position
//   sof_o        - the word issued now is the first word of a frame
//   eol_o        - the word issued now is the last word of a line
//   eof_o        - the word issued now is the last word of a frame
// The flags describe the current position, so the producer captures them
// alongside the word in the same cycle that it asserts advance_i.
module axis_frame_counter #(
    parameter int X_WORDS = 384,
    parameter int Y_LINES = 512
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic advance_i,
    output logic sof_o,
    output logic eol_o,
    output logic eof_o
);
    localparam int WW = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
    localparam int LW = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;

    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic          word_last_s;
    logic          line_last_s;

    assign word_last_s = (word_cnt_q == WW'(X_WORDS - 1));
    assign line_last_s = (line_cnt_q == LW'(Y_LINES - 1));
    assign sof_o       = (word_cnt_q == '0) && (line_cnt_q == '0);
    assign eol_o       = word_last_s;
    assign eof_o       = word_last_s && line_last_s;

    // Next position: step the word counter, carrying into the line counter at end of line.
    always_comb begin
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        if (advance_i) begin
            if (word_last_s) begin
                word_cnt_d = '0;
                line_cnt_d = line_last_s ? '0 : (line_cnt_q + LW'(1));
            end else begin
                word_cnt_d = word_cnt_q + WW'(1);
            end
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI-Stream words (4 pixels -> 3 words)
// and adds video framing (tuser = start of frame, tlast = end of line).
// Ports:
//   out_stream_aclk, rst - clock and synchronous active-high reset
//   in_pixel/in_valid/in_ready - pixel input handshake ({R,G,B}, B is LSB)
//   out_stream          - AXI-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   frame_done          - one-cycle pulse after the last word of a frame transfers
module pixel_packer
    import pixgen_pkg::*;
#(
    parameter int X_PIXELS = 512,
    parameter int Y_LINES  = 512
) (
    input  logic                out_stream_aclk,
    input  logic                rst,
    input  logic [PIX_BITS-1:0] in_pixel,
    input  logic                in_valid,
    output logic                in_ready,
    pixel_packer_if.master      out_stream,
    output logic                frame_done
);
    localparam int X_WORDS = words_per_line(X_PIXELS);

    if ((X_PIXELS % PIX_PER_GROUP) != 0) begin : g_bad_line_length
        $fatal(1, "pixel_packer: X_PIXELS must be a multiple of 4");
    end

    phase_e                 phase_q, phase_d;
    logic [PIX_BITS-1:0]    hold_q, hold_d;
    logic [WORD_BITS-1:0]   tdata_q, word_s;
    logic                   tlast_q, tuser_q, tvalid_q, eof_q, frame_done_q;
    rgb_t                   pix_s;
    logic                   accept_s, load_s, xfer_s;
    logic                   sof_s, eol_s, eof_s;

    assign pix_s = rgb_t'(in_pixel);

    // Phase 0 only fills the hold register, so it may proceed while a word is stalled.
    assign in_ready = (phase_q == PH0) || !tvalid_q || out_stream.tready;
    assign accept_s = in_valid && in_ready;
    assign load_s   = accept_s && (phase_q != PH0);
    assign xfer_s   = tvalid_q && out_stream.tready;

    axis_frame_counter #(
        .X_WORDS (X_WORDS),
        .Y_LINES (Y_LINES)
    ) u_frame_counter (
        .clk_i     (out_stream_aclk),
        .rst_i     (rst),
        .advance_i (load_s),
        .sof_o     (sof_s),
        .eol_o     (eol_s),
        .eof_o     (eof_s)
    );

    // Packing datapath: combine held bytes with the incoming pixel, keep the leftover bytes.
    always_comb begin
        phase_d = phase_q;
        hold_d  = hold_q;
        word_s  = tdata_q;
        if (accept_s) begin
            phase_d = phase_e'(phase_q + 2'd1);
            case (phase_q)
                PH0: begin
                    hold_d = pix_s;
                end
                PH1: begin
                    word_s = {pix_s.b, hold_q};
                    hold_d = {8'h00, pix_s.r, pix_s.g};
                end
                PH2: begin
                    word_s = {pix_s.g, pix_s.b, hold_q[15:0]};
                    hold_d = {16'h0000, pix_s.r};
                end
                PH3: begin
                    word_s = {pix_s, hold_q[7:0]};
                    hold_d = 24'h000000;
                end
                default: begin
                    hold_d = hold_q;
                end
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase/hold state and output word register; a load overrides a same-cycle transfer.
    always_ff @(posedge out_stream_aclk) begin
        if (rst) begin
            phase_q      <= PH0;
            hold_q       <= '0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            frame_done_q <= xfer_s && eof_q;
            if (load_s) begin
                tdata_q  <= word_s;
                tlast_q  <= eol_s;
                tuser_q  <= sof_s;
                eof_q    <= eof_s;
                tvalid_q <= 1'b1;
            end else if (xfer_s) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign out_stream.tdata  = tdata_q;
    assign out_stream.tkeep  = 4'hF;
    assign out_stream.tlast  = tlast_q;
    assign out_stream.tuser  = tuser_q;
    assign out_stream.tvalid = tvalid_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer. A byte-queue reference model on the
// negative clock edge predicts every transferred word and its framing; directed
// tables and sequences cover packing order, line length, stalls and reset.
module tb_pixel_packer;
    import pixgen_pkg::*;

    localparam int XP = 512;
    localparam int YL = 4;
    localparam int XW = XP * 3 / 4;
    localparam int FRAME_PIX = XP * YL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_pixel = 24'h000000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_done;

    pixel_packer_if out_stream ();

    pixel_packer #(.X_PIXELS(XP), .Y_LINES(YL)) dut (
        .out_stream_aclk (clk),
        .rst             (rst),
        .in_pixel        (in_pixel),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_stream      (out_stream),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        user;
        logic        eof;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  byteq[$];
    int          gen_idx = 0;
    int          xfer_cnt = 0;
    int          tlast_cnt = 0;
    int          last_tlast_idx = -1;
    int          fd_cnt = 0;
    int          fd_first_idx = -1;
    logic        pend_fd = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] s_d;
    logic        s_l, s_u;

    always @(negedge clk) begin
        exp_t e;
        chk("frame_done", {31'b0, frame_done}, {31'b0, pend_fd});
        if (frame_done === 1'b1) begin
            if (fd_cnt == 0) fd_first_idx = xfer_cnt;
            fd_cnt++;
        end
        if (stall) begin
            chk("stall_tvalid", {31'b0, out_stream.tvalid}, 32'd1);
            chk("stall_tdata", out_stream.tdata, s_d);
            chk("stall_tlast", {31'b0, out_stream.tlast}, {31'b0, s_l});
            chk("stall_tuser", {31'b0, out_stream.tuser}, {31'b0, s_u});
        end
        if (rst) begin
            expq.delete();
            byteq.delete();
            gen_idx = 0; xfer_cnt = 0; tlast_cnt = 0; last_tlast_idx = -1;
            fd_cnt = 0; fd_first_idx = -1; pend_fd = 1'b0; stall = 1'b0;
        end else begin
            chk("tvalid_vs_model", {31'b0, out_stream.tvalid}, (expq.size() != 0) ? 32'd1 : 32'd0);
            pend_fd = 1'b0;
            stall = (out_stream.tvalid === 1'b1) && (out_stream.tready === 1'b0);
            s_d = out_stream.tdata; s_l = out_stream.tlast; s_u = out_stream.tuser;
            if (out_stream.tvalid === 1'b1 && out_stream.tready === 1'b1 && expq.size() != 0) begin
                e = expq.pop_front();
                chk("tdata", out_stream.tdata, e.d);
                chk("tlast", {31'b0, out_stream.tlast}, {31'b0, e.last});
                chk("tuser", {31'b0, out_stream.tuser}, {31'b0, e.user});
                chk("tkeep", {28'b0, out_stream.tkeep}, 32'hF);
                pend_fd = e.eof;
                if (out_stream.tlast === 1'b1) begin
                    tlast_cnt++;
                    last_tlast_idx = xfer_cnt;
                end
                xfer_cnt++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                byteq.push_back(in_pixel[7:0]);
                byteq.push_back(in_pixel[15:8]);
                byteq.push_back(in_pixel[23:16]);
                while (byteq.size() >= 4) begin
                    int wl, ln;
                    e.d = {byteq[3], byteq[2], byteq[1], byteq[0]};
                    repeat (4) void'(byteq.pop_front());
                    wl = gen_idx % XW;
                    ln = (gen_idx / XW) % YL;
                    e.user = (wl == 0) && (ln == 0);
                    e.last = (wl == XW - 1);
                    e.eof  = e.last && (ln == YL - 1);
                    gen_idx++;
                    expq.push_back(e);
                end
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [23:0] pix;
        logic        exp_v;
        logic [31:0] exp_w;
        logic        exp_u;
    } vec_t;

    vec_t vt[8];

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n_sent;
        vt[0] = '{24'h030201, 1'b0, 32'h00000000, 1'b0};
        vt[1] = '{24'h060504, 1'b1, 32'h04030201, 1'b1};
        vt[2] = '{24'h090807, 1'b1, 32'h08070605, 1'b0};
        vt[3] = '{24'h0C0B0A, 1'b1, 32'h0C0B0A09, 1'b0};
        vt[4] = '{24'h0F0E0D, 1'b0, 32'h00000000, 1'b0};
        vt[5] = '{24'h121110, 1'b1, 32'h100F0E0D, 1'b0};
        vt[6] = '{24'h151413, 1'b1, 32'h14131211, 1'b0};
        vt[7] = '{24'h181716, 1'b1, 32'h18171615, 1'b0};

        out_stream.tready = 1'b1;
        tick();
        tick();
        // reset state
        chk("rst_tvalid", {31'b0, out_stream.tvalid}, 32'd0);
        chk("rst_tdata", out_stream.tdata, 32'd0);
        chk("rst_tlast", {31'b0, out_stream.tlast}, 32'd0);
        chk("rst_tuser", {31'b0, out_stream.tuser}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // packing order, always ready
        for (int i = 0; i < 8; i++) begin
            in_pixel = vt[i].pix;
            in_valid = 1'b1;
            #1;
            chk("tbl_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
            chk("tbl_tvalid", {31'b0, out_stream.tvalid}, {31'b0, vt[i].exp_v});
            if (vt[i].exp_v) begin
                chk("tbl_tdata", out_stream.tdata, vt[i].exp_w);
                chk("tbl_tuser", {31'b0, out_stream.tuser}, {31'b0, vt[i].exp_u});
                chk("tbl_tkeep", {28'b0, out_stream.tkeep}, 32'hF);
            end
        end
        in_valid = 1'b0;
        tick();

        // one full line, always ready
        do_reset();
        for (int i = 0; i < XP; i++) begin
            in_pixel = 24'(i * 3);
            in_valid = 1'b1;
            #1;
            chk("line_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("line_word_count", 32'(xfer_cnt), 32'(XW));
        chk("line_tlast_count", 32'(tlast_cnt), 32'd1);
        chk("line_tlast_index", 32'(last_tlast_idx), 32'(XW - 1));

        // two frames with random valid and random ready
        do_reset();
        n_sent = 0;
        for (int c = 0; c < 40000 && n_sent < 2 * FRAME_PIX; c++) begin
            in_valid = ($urandom_range(9) < 7) ? 1'b1 : 1'b0;
            in_pixel = 24'($urandom);
            out_stream.tready = $urandom_range(1) == 1 ? 1'b1 : 1'b0;
            #1;
            if (in_valid && in_ready) n_sent++;
            tick();
        end
        chk("rand_pixels_sent", 32'(n_sent), 32'(2 * FRAME_PIX));
        in_valid = 1'b0;
        out_stream.tready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("rand_drained", 32'(expq.size()), 32'd0);
        chk("rand_word_count", 32'(xfer_cnt), 32'(2 * FRAME_PIX * 3 / 4));
        chk("frame_done_count", 32'(fd_cnt), 32'd2);
        chk("frame_done_first_at", 32'(fd_first_idx), 32'(FRAME_PIX * 3 / 4));

        // reset in the middle of the second line
        for (int i = 0; i < XP + 2; i++) begin
            in_pixel = 24'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tvalid", {31'b0, out_stream.tvalid}, 32'd0);
        chk("midrst_tdata", out_stream.tdata, 32'd0);
        in_valid = 1'b1;
        in_pixel = 24'h332211; tick();
        in_pixel = 24'h665544; tick();
        chk("midrst_w0", out_stream.tdata, 32'h44332211);
        chk("midrst_w0_tuser", {31'b0, out_stream.tuser}, 32'd1);
        in_pixel = 24'h998877; tick();
        chk("midrst_w1", out_stream.tdata, 32'h88776655);
        chk("midrst_w1_tuser", {31'b0, out_stream.tuser}, 32'd0);
        in_pixel = 24'hCCBBAA; tick();
        chk("midrst_w2", out_stream.tdata, 32'hCCBBAA99);
        in_valid = 1'b0;
        tick();

        // long stall after a phase-1 word
        do_reset();
        out_stream.tready = 1'b0;
        in_valid = 1'b1;
        in_pixel = 24'h010203; tick();
        in_pixel = 24'h040506;
        #1;
        chk("stall_p1_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_pixel = 24'h070809;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("stall_p2_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        chk("stall_held_word", out_stream.tdata, 32'h06010203);
        out_stream.tready = 1'b1;
        tick();
        in_pixel = 24'h0A0B0C; tick();
        out_stream.tready = 1'b0;
        in_pixel = 24'h0D0E0F;
        #1;
        chk("stall_p0_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_pixel = 24'h101112;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_p1b_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_stream.tready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_drained", 32'(expq.size()), 32'd0);
        chk("stall_word_count", 32'(xfer_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
